// File: rtl/bm_rd_sched_pkg.sv
// Shared types for the bias-memory read scheduler. The BM_* sizing macros normally
// come from the shared incl.vh; the fallbacks below keep a standalone build complete.
`ifndef BM_DATA_WIDTH
`define BM_DATA_WIDTH 32
`endif
`ifndef BM_DEPTH
`define BM_DEPTH 512
`endif
`ifndef BM_NUM_PIPE
`define BM_NUM_PIPE 1
`endif

package bm_rd_sched_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } rd_tag_t;

    localparam rd_tag_t TAG_NONE = '{valid: 1'b0, id: 1'b0, last: 1'b0};

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bm_rd_sched_if.sv
// Requester-side bus of the BM read scheduler: two burst requesters plus the tagged response stream.
interface bm_rd_sched_if #(
    parameter int AW         = 9,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [2*AW-1:0]       req_addr;
    logic [2*AW-1:0]       req_len;
    logic                  rsp_valid;
    logic                  rsp_id;
    logic                  rsp_last;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_addr, req_len,
        input  req_ready, rsp_valid, rsp_id, rsp_last, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_len,
        output req_ready, rsp_valid, rsp_id, rsp_last, rsp_data
    );

endinterface

// File: rtl/bm_rd_sched_rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the loser only when a grant is actually taken.
module rr_arb2
    import bm_rd_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       accept_en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       grant_id,
    output logic       grant_any
);

    logic rr_ptr;

    always_comb begin
        grant_id = rr_ptr;
        case (req)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            default: grant_id = rr_ptr;
        endcase
        grant_any = accept_en & (|req);
        grant     = grant_any ? id_to_onehot(grant_id) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (grant_any) begin
            rr_ptr <= ~grant_id;
        end
    end

endmodule

// File: rtl/bm_rd_sched.sv
// BM read scheduler: arbitrates two burst requesters onto the single BM read port and tags returns.
// Optional BM_RD_SCHED_COLLISION_CHK_EN stalls a read whose address is being written that cycle.
module bm_rd_sched
    import bm_rd_sched_pkg::*;
#(
    parameter int  DATA_WIDTH = `BM_DATA_WIDTH,
    parameter int  DEPTH      = `BM_DEPTH,
    parameter int  RD_LAT     = `BM_NUM_PIPE + 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    bm_rd_sched_if.slave          bus,
    input  logic                  ld_wr_en,
    input  logic [AW-1:0]         ld_wr_addr,
    input  logic [DATA_WIDTH-1:0] ld_din,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  mem_wr_en,
    output logic [AW-1:0]         mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  busy
);

    sched_state_t state, state_nxt;
    logic          cur_id;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] beats_left;
    logic          stall, issue, last_issue, accept_en;
    logic [1:0]    grant;
    logic          grant_id, grant_any;
    logic [AW-1:0] sel_addr, sel_len;
    rd_tag_t       tag_pipe [RD_LAT];
    logic          any_inflight;

`ifdef BM_RD_SCHED_COLLISION_CHK_EN
    assign stall = (state == ST_BURST) && ld_wr_en && (ld_wr_addr == cur_addr);
`else
    assign stall = 1'b0;
`endif

    // The cycle issuing the final beat doubles as an accept point so bursts chain without bubbles.
    assign issue      = (state == ST_BURST) && !stall;
    assign last_issue = issue && (beats_left == '0);
    assign accept_en  = (state == ST_IDLE) || last_issue;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .accept_en (accept_en),
        .req       (bus.req_valid),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign sel_addr = grant_id ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
    assign sel_len  = grant_id ? bus.req_len[2*AW-1:AW]  : bus.req_len[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant_any) state_nxt = ST_BURST;
            ST_BURST: if (last_issue && !grant_any) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_id     <= 1'b0;
            cur_addr   <= '0;
            beats_left <= '0;
        end else if (grant_any) begin
            cur_id     <= grant_id;
            cur_addr   <= sel_addr;
            beats_left <= sel_len;
        end else if (issue) begin
            cur_addr   <= cur_addr + 1'b1;
            beats_left <= beats_left - 1'b1;
        end
    end

    // Tags travel alongside the BRAM read latency so each returning word knows its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
        end else begin
            tag_pipe[0] <= '{valid: issue, id: cur_id, last: last_issue};
            for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_comb begin
        any_inflight = 1'b0;
        for (int i = 0; i < RD_LAT; i++) any_inflight = any_inflight | tag_pipe[i].valid;
    end

    always_comb begin
        mem_rd_en     = issue;
        mem_rd_addr   = cur_addr;
        mem_wr_en     = ld_wr_en;
        mem_wr_addr   = ld_wr_addr;
        mem_din       = ld_din;
        bus.req_ready = grant;
        bus.rsp_valid = tag_pipe[RD_LAT-1].valid;
        bus.rsp_id    = tag_pipe[RD_LAT-1].id;
        bus.rsp_last  = tag_pipe[RD_LAT-1].last;
        bus.rsp_data  = mem_dout;
        busy          = (state == ST_BURST) || any_inflight;
    end

endmodule

// File: tb/tb_bm_rd_sched.sv
// Self-checking bench for bm_rd_sched: a transaction-level scheduler model predicts every cycle,
// a BRAM model sits behind the memory port, and a negedge process compares against the prediction.
module tb_bm_rd_sched;
    import bm_rd_sched_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int RL    = `BM_NUM_PIPE + 1;
    localparam int MAXW  = 600;
`ifdef BM_RD_SCHED_COLLISION_CHK_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bm_rd_sched_if #(.AW(AW), .DATA_WIDTH(DW)) bus ();

    logic          ld_wr_en;
    logic [AW-1:0] ld_wr_addr;
    logic [DW-1:0] ld_din;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_dout;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_din;
    logic          busy;

    bm_rd_sched #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LAT(RL)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ld_wr_en    (ld_wr_en),
        .ld_wr_addr  (ld_wr_addr),
        .ld_din      (ld_din),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_dout    (mem_dout),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_din     (mem_din),
        .busy        (busy)
    );

    // BRAM with RL-cycle read latency and read-before-write on a same-address collision
    logic [DW-1:0] bram    [DEPTH];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (mem_rd_en) rd_pipe[0] <= bram[mem_rd_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_wr_en) bram[mem_wr_addr] <= mem_din;
    end
    assign mem_dout = rd_pipe[RL-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference memory contents and the per-test request description
    logic [DW-1:0] ref_mem [DEPTH];
    int  t_valid [2];
    int  t_start [2];
    int  t_addr  [2];
    int  t_len   [2];
    int  t_wr_at, t_wr_addr, t_rst_at;
    logic [DW-1:0] t_wr_data;
    int  mdl_rr = 0;

    // Predicted per-cycle behaviour, indexed by cycle offset inside a test window
    bit            exp_rd_en     [MAXW];
    int            exp_rd_addr   [MAXW];
    bit            exp_rsp_valid [MAXW];
    bit            exp_rsp_id    [MAXW];
    bit            exp_rsp_last  [MAXW];
    logic [DW-1:0] exp_rsp_data  [MAXW];
    bit   [1:0]    exp_ready     [MAXW];
    bit            exp_busy      [MAXW];

    bit chk_on = 1'b0;
    int base   = 0;
    int rsp_log [$];

    function automatic logic [DW-1:0] pattern(input int i);
        return DW'(32'hB000_0000 + i * 32'h0001_0003);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic setTest(input int v0, input int s0, input int a0, input int l0,
                           input int v1, input int s1, input int a1, input int l1);
        t_valid[0] = v0; t_start[0] = s0; t_addr[0] = a0; t_len[0] = l0;
        t_valid[1] = v1; t_start[1] = s1; t_addr[1] = a1; t_len[1] = l1;
        t_wr_at = -1; t_wr_addr = 0; t_wr_data = '0; t_rst_at = -1;
    endtask

    // Burst-level model: pick a winner at each free point, lay its beats out in time, derive the rest
    task automatic planModel();
        bit pend [2];
        int free_at, a, g, c, addr, n, last_c, s0, s1;
        for (int k = 0; k < MAXW; k++) begin
            exp_rd_en[k] = 0; exp_rd_addr[k] = 0; exp_rsp_valid[k] = 0; exp_rsp_id[k] = 0;
            exp_rsp_last[k] = 0; exp_rsp_data[k] = '0; exp_ready[k] = 2'b00; exp_busy[k] = 0;
        end
        pend[0] = (t_valid[0] != 0);
        pend[1] = (t_valid[1] != 0);
        free_at = 0;
        last_c  = 0;
        while (pend[0] || pend[1]) begin
            s0 = pend[0] ? t_start[0] : MAXW;
            s1 = pend[1] ? t_start[1] : MAXW;
            a  = (s0 < s1) ? s0 : s1;
            if (free_at > a) a = free_at;
            if (t_rst_at >= 0 && a > t_rst_at) break;
            if (pend[0] && pend[1] && s0 <= a && s1 <= a) g = mdl_rr;
            else if (pend[0] && s0 <= a) g = 0;
            else g = 1;
            mdl_rr = 1 - g;
            exp_ready[a] = (g == 1) ? 2'b10 : 2'b01;
            addr = t_addr[g];
            n    = t_len[g] + 1;
            c    = a + 1;
            while (n > 0) begin
                if (COLL && c == t_wr_at && addr == t_wr_addr) begin
                    exp_busy[c] = 1;
                    c++;
                end else begin
                    exp_rd_en[c]       = 1;
                    exp_rd_addr[c]     = addr;
                    exp_busy[c]        = 1;
                    exp_rsp_valid[c+RL] = 1;
                    exp_rsp_id[c+RL]    = (g == 1);
                    exp_rsp_last[c+RL]  = (n == 1);
                    exp_rsp_data[c+RL]  = (t_wr_at >= 0 && c > t_wr_at && addr == t_wr_addr)
                                          ? t_wr_data : ref_mem[addr];
                    for (int d = 1; d <= RL; d++) exp_busy[c+d] = 1;
                    last_c = c;
                    addr   = (addr + 1) % (1 << AW);
                    n--;
                    c++;
                end
            end
            free_at = last_c;
            pend[g] = 0;
        end
        if (t_rst_at >= 0) begin
            for (int k = t_rst_at + 1; k < MAXW; k++) begin
                exp_rd_en[k] = 0; exp_rsp_valid[k] = 0; exp_ready[k] = 2'b00; exp_busy[k] = 0;
            end
            mdl_rr = 0;
        end
    endtask

    // Drives one test window; requesters hold valid until their own accept is seen
    task automatic applyStimulus(input int win);
        bit [1:0] done;
        done = 2'b00;
        bus.req_addr = {AW'(t_addr[1]), AW'(t_addr[0])};
        bus.req_len  = {AW'(t_len[1]),  AW'(t_len[0])};
        rsp_log.delete();
        base   = cyc;
        chk_on = 1'b1;
        for (int k = 0; k < win; k++) begin
            for (int r = 0; r < 2; r++)
                bus.req_valid[r] = (t_valid[r] != 0) && !done[r] && (k >= t_start[r]) &&
                                   (t_rst_at < 0 || k <= t_rst_at);
            ld_wr_en   = (k == t_wr_at);
            ld_wr_addr = AW'(t_wr_addr);
            ld_din     = t_wr_data;
            rst        = (k == t_rst_at);
            @(negedge clk);
            done = done | (bus.req_valid & bus.req_ready);
            @(posedge clk);
            #1;
        end
        chk_on        = 1'b0;
        bus.req_valid = 2'b00;
        ld_wr_en      = 1'b0;
        rst           = 1'b0;
        if (t_wr_at >= 0) ref_mem[t_wr_addr] = t_wr_data;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mdl_rr = 0;
        checkOutput("rst req_ready", bus.req_ready, 2'b00);
        checkOutput("rst rsp_valid", bus.rsp_valid, 1'b0);
        checkOutput("rst rsp_id", bus.rsp_id, 1'b0);
        checkOutput("rst rsp_last", bus.rsp_last, 1'b0);
        checkOutput("rst mem_rd_en", mem_rd_en, 1'b0);
        checkOutput("rst mem_rd_addr", mem_rd_addr, '0);
        checkOutput("rst busy", busy, 1'b0);
    endtask

    // Cycle-by-cycle comparison against the model while a test window is open
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                int k;
                k = cyc - base;
                if (k >= 0 && k < MAXW) begin
                    checkOutput("mem_rd_en", mem_rd_en, exp_rd_en[k]);
                    if (exp_rd_en[k]) checkOutput("mem_rd_addr", mem_rd_addr, exp_rd_addr[k]);
                    checkOutput("req_ready", bus.req_ready, exp_ready[k]);
                    checkOutput("rsp_valid", bus.rsp_valid, exp_rsp_valid[k]);
                    if (exp_rsp_valid[k]) begin
                        checkOutput("rsp_id", bus.rsp_id, exp_rsp_id[k]);
                        checkOutput("rsp_last", bus.rsp_last, exp_rsp_last[k]);
                        checkOutput("rsp_data", bus.rsp_data, exp_rsp_data[k]);
                    end
                    checkOutput("busy", busy, exp_busy[k]);
                    checkOutput("wr_en passthru", mem_wr_en, ld_wr_en);
                    if (ld_wr_en) begin
                        checkOutput("wr_addr passthru", mem_wr_addr, ld_wr_addr);
                        checkOutput("wr_data passthru", mem_din, ld_din);
                    end
                    if (t_rst_at >= 0 && k > t_rst_at) begin
                        checkOutput("post-rst rsp_id", bus.rsp_id, 1'b0);
                        checkOutput("post-rst rsp_last", bus.rsp_last, 1'b0);
                        checkOutput("post-rst mem_rd_addr", mem_rd_addr, '0);
                    end
                    if (bus.rsp_valid) rsp_log.push_back(int'(bus.rsp_id));
                end
            end
        end
    end

    initial begin
        bus.req_valid = 2'b00;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        ld_wr_en      = 1'b0;
        ld_wr_addr    = '0;
        ld_din        = '0;
        @(posedge clk);
        #1;
        doReset();

        for (int i = 0; i < DEPTH; i++) begin
            ld_wr_en   = 1'b1;
            ld_wr_addr = AW'(i);
            ld_din     = pattern(i);
            ref_mem[i] = pattern(i);
            @(posedge clk);
            #1;
        end
        ld_wr_en = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single burst req0 addr=5 len=3");
        setTest(1, 0, 5, 3, 0, 0, 0, 0);
        planModel();
        checkOutput("model first addr", exp_rd_addr[1], 5);
        checkOutput("model fourth addr", exp_rd_addr[4], 8);
        checkOutput("model first rsp", exp_rsp_valid[1+RL], 1);
        checkOutput("model no early rsp", exp_rsp_valid[RL], 0);
        checkOutput("model last on beat4", exp_rsp_last[4+RL], 1);
        checkOutput("model no last on beat3", exp_rsp_last[3+RL], 0);
        checkOutput("model beat1 data", exp_rsp_data[1+RL], 32'hB005_000F);
        applyStimulus(16);

        $display("[TB] simultaneous requests from reset");
        doReset();
        setTest(1, 0, 20, 1, 1, 0, 40, 1);
        planModel();
        applyStimulus(16);
        checkOutput("arb rsp count", rsp_log.size(), 4);
        if (rsp_log.size() == 4) begin
            checkOutput("arb id beat1", rsp_log[0], 0);
            checkOutput("arb id beat2", rsp_log[1], 0);
            checkOutput("arb id beat3", rsp_log[2], 1);
            checkOutput("arb id beat4", rsp_log[3], 1);
        end

        $display("[TB] address wrap");
        setTest(0, 0, 0, 0, 1, 0, 510, 3);
        planModel();
        checkOutput("model pre-wrap addr", exp_rd_addr[2], 511);
        checkOutput("model wrapped addr", exp_rd_addr[3], 0);
        applyStimulus(16);

        $display("[TB] back-to-back len=0 then len=2");
        setTest(1, 0, 100, 0, 1, 0, 200, 2);
        planModel();
        applyStimulus(16);

        $display("[TB] staggered requests with idle accept");
        setTest(1, 3, 301, 1, 1, 0, 300, 0);
        planModel();
        applyStimulus(16);

        $display("[TB] loader write to address being read");
        setTest(1, 0, 5, 3, 0, 0, 0, 0);
        t_wr_at = 3; t_wr_addr = 7; t_wr_data = 32'h0000_00A5;
        planModel();
`ifdef BM_RD_SCHED_COLLISION_CHK_EN
        checkOutput("model stall gap", exp_rd_en[3], 0);
        checkOutput("model new data", exp_rsp_data[4+RL], 32'h0000_00A5);
`else
        checkOutput("model no gap", exp_rd_addr[3], 7);
        checkOutput("model old data", exp_rsp_data[3+RL], pattern(7));
`endif
        applyStimulus(16);

        $display("[TB] reset during 8-beat burst");
        setTest(1, 0, 50, 7, 0, 0, 0, 0);
        t_rst_at = 1 + RL + 2;
        planModel();
        applyStimulus(20);

        $display("[TB] full-memory burst");
        setTest(0, 0, 0, 0, 1, 0, 0, DEPTH - 1);
        planModel();
        applyStimulus(DEPTH + RL + 8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bm_rd_sched.md
# bm_rd_sched

Read scheduler and arbiter for the bias memory (BM). It sits directly in front of the BM simple-dual-port BRAM instance. It shares the single BM read port between two burst requesters: requester 0 is the convolution engine's bias fetcher, requester 1 is the FC/post-processing fetcher. It issues one read per cycle and routes the pipelined read data back, tagged with requester id and a last-beat flag. The write port is passed through from the BM loader, with an optional read/write collision guard.

## Interface
Parameters:
- DATA_WIDTH, default `BM_DATA_WIDTH: BM word width.
- DEPTH, default `BM_DEPTH: BM word count. AW = $clog2(DEPTH).
- RD_LAT, default `BM_NUM_PIPE+1: cycles from mem_rd_en to valid mem_dout.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, 2: burst request valid, one bit per requester.
- req_ready, output, 2: burst accepted in the cycle where req_valid&req_ready.
- req_addr, input, 2*AW: start address. Requester r occupies [r*AW +: AW].
- req_len, input, 2*AW: burst length minus 1.
- rsp_valid, output, 1: read data valid.
- rsp_id, output, 1: requester owning rsp_data.
- rsp_last, output, 1: final beat of a burst.
- rsp_data, output, DATA_WIDTH: read data.
- ld_wr_en, input, 1: loader write strobe.
- ld_wr_addr, input, AW: loader write address.
- ld_din, input, DATA_WIDTH: loader write data.
- mem_rd_en, output, 1: to BM.
- mem_rd_addr, output, AW: to BM.
- mem_dout, input, DATA_WIDTH: from BM.
- mem_wr_en, output, 1: to BM.
- mem_wr_addr, output, AW: to BM.
- mem_din, output, DATA_WIDTH: to BM.
- busy, output, 1: burst in progress or data in flight.

## Operation
- Two states, IDLE and BURST. Registers: cur_id, cur_addr, beats_left (AW bits), rr_ptr (1 bit).
- Accept point: in IDLE, or in the BURST cycle that issues the last beat, the arbiter grants at most one requester.
  - If both requesters are valid, grant the one rr_ptr points to; rr_ptr then flips to the other.
  - If one is valid, grant it; rr_ptr = the non-granted id.
- req_ready is combinational and only asserted at an accept point.
- Accept: cur_addr <= req_addr, beats_left <= req_len, cur_id <= granted id, next state BURST.
- BURST issues mem_rd_en=1 every cycle with mem_rd_addr=cur_addr.
  - cur_addr increments modulo 2^AW. A burst crossing DEPTH-1 wraps to 0; addresses ≥ DEPTH when DEPTH is not a power of two are the requester's error.
  - beats_left decrements. The beat issued with beats_left==0 is last.
  - After the last beat: go to IDLE, or stay in BURST if a new burst was accepted in the same cycle.
- Tag pipeline: an RD_LAT-deep shift of {valid, id, last} tracks each issued read. Its output drives rsp_valid/rsp_id/rsp_last. rsp_data = mem_dout directly.
- No response backpressure: consumers must sink every beat.
- Write path: mem_wr_* = ld_wr_* combinationally. Writes are never stalled.
- busy = (state==BURST) | any pipeline valid.

## Timing
- Reset values: state IDLE, rr_ptr=0, pipeline valids 0. Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_last=0, mem_rd_en=0, mem_rd_addr=0, busy=0.
- rst mid-burst: the burst is abandoned and in-flight responses are dropped (no rsp_valid after reset). Requesters must re-issue.
- Latency: request accepted at cycle T, first mem_rd_en at T+1, first rsp_valid at T+1+RD_LAT.
- Throughput: one beat per cycle, zero bubbles between back-to-back bursts. A len=0 burst costs one cycle.
- req_len = DEPTH-1 reads the full memory once.

## Configuration
- BM_RD_SCHED_COLLISION_CHK_EN defined: a cycle in BURST with ld_wr_en=1 and ld_wr_addr==cur_addr holds mem_rd_en=0. cur_addr and beats_left do not advance, and no tag enters the pipeline. The read retries the next cycle and so returns the newly written data.
- Not defined: no stall. A same-address read/write returns BRAM old-data behaviour.

## Structure
- `BM_DATA_WIDTH, `BM_DEPTH and `BM_NUM_PIPE come from the shared incl.vh. The macro BM_RD_SCHED_COLLISION_CHK_EN is also defined there when enabled.
- One sub-module: rr_arb2, a two-way round-robin grant with pointer update on accept.
- The tag pipeline stays inline.

## Test plan
- Single burst, req0, addr=5, len=3: reads issued to 5,6,7,8 in cycles T+1..T+4. rsp_valid for 4 beats starting at T+1+RD_LAT, rsp_id=0, rsp_last only on the 4th beat, data matches preload.
- Both requesters valid simultaneously from reset, len=1 each: req0 granted first, then req1 granted in req0's last-issue cycle. Four consecutive rsp beats with ids 0,0,1,1. rr_ptr=0 afterwards.
- Wrap: DEPTH=512, addr=510, len=3: addresses 510,511,0,1 issued.
- Reset asserted two cycles after the first rsp_valid of an 8-beat burst: all outputs return to reset values next cycle, and no further rsp_valid appears.
- With BM_RD_SCHED_COLLISION_CHK_EN, loader writes 0xA5 to addr 7 in the cycle the burst would read addr 7: one-cycle issue gap, and the beat for addr 7 returns 0xA5. Without the macro: no gap, and the old value is returned.
